// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Brief    : Two-port req/ack arbiter sharing one single-port data RAM.
// Revision : 1.0  initial release
// ============================================================================
module data_ram_arbiter #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 1024,
   parameter int PRIORITY_MODE = 0
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  err0,
   output logic                  err1,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ramAddress,
   output logic [DATA_WIDTH-1:0] ramDataC,
   output logic                  ramWriteEnable,
   input  logic [DATA_WIDTH-1:0] ramDataOutput
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    rr_ptr;
   logic                    served;
   logic                    we_lat;
   logic                    in_range_lat;

   logic                    cand0;
   logic                    cand1;
   logic                    grant_valid;
   logic                    grant_port;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    sel_in_range;

   // Arbitration is open in IDLE and in ACK; in ACK the port just served is masked.
   always_comb begin
      cand0       = 1'b0;
      cand1       = 1'b0;
      grant_port  = 1'b0;
      if (state == IDLE) begin
         cand0 = req0;
         cand1 = req1;
      end else if (state == ACK) begin
         cand0 = req0 & served;
         cand1 = req1 & ~served;
      end
      grant_valid = cand0 | cand1;
      if (cand0 & cand1) begin
         grant_port = (PRIORITY_MODE == 1) ? 1'b0 : rr_ptr;
      end else begin
         grant_port = cand1;
      end
   end

   always_comb begin
      sel_we       = grant_port ? we1    : we0;
      sel_addr     = grant_port ? addr1  : addr0;
      sel_wdata    = grant_port ? wdata1 : wdata0;
      sel_in_range = ({1'b0, sel_addr} < DEPTH_LIMIT);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = ACCESS;
         ACCESS:  state_next = ACK;
         ACK:     state_next = grant_valid ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         rr_ptr       <= 1'b0;
         served       <= 1'b0;
         we_lat       <= 1'b0;
         in_range_lat <= 1'b0;
         ramAddress   <= '0;
         ramDataC     <= '0;
         rdata0       <= '0;
         rdata1       <= '0;
      end else begin
         state <= state_next;
         if (grant_valid) begin
            served       <= grant_port;
            rr_ptr       <= ~grant_port;
            we_lat       <= sel_we;
            in_range_lat <= sel_in_range;
            ramAddress   <= sel_addr;
            ramDataC     <= sel_wdata;
         end
         // Read data is captured at the edge that closes ACCESS.
         if ((state == ACCESS) && !we_lat) begin
            if (served) begin
               rdata1 <= in_range_lat ? ramDataOutput : '0;
            end else begin
               rdata0 <= in_range_lat ? ramDataOutput : '0;
            end
         end
      end
   end

   // Decoded from state so the write strobe falls as soon as reset asserts.
   assign ramWriteEnable = (state == ACCESS) & we_lat & in_range_lat;
   assign ack0           = (state == ACK) & ~served;
   assign ack1           = (state == ACK) &  served;
   assign err0           = ack0 & ~in_range_lat;
   assign err1           = ack1 & ~in_range_lat;
   assign busy           = (state != IDLE);

endmodule
`default_nettype wire
